// File: rtl/tick_counter_seg7_if.sv
// tick_counter_seg7_if: control, status and display signals of the tick counter
interface tick_counter_seg7_if;
  logic tickIn;
  logic en;
  logic up;
  logic load;
  logic [3:0] loadVal;
  logic [3:0] count;
  logic [6:0] seg;
  logic tc;
  modport master (output tickIn, en, up, load, loadVal, input count, seg, tc);
  modport slave (input tickIn, en, up, load, loadVal, output count, seg, tc);
endinterface

// File: rtl/tick_counter_seg7.sv
// tick_counter_seg7: steps a wrapping 4-bit counter on each synchronised tickIn rise and drives its 7-segment pattern
module tick_counter_seg7 #(
  parameter int MAX_VAL = 15,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  tick_counter_seg7_if.slave bus
);
  localparam logic [3:0] MAX = 4'(MAX_VAL);
  function automatic logic [6:0] hex(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction
  logic s1, s2, p;
  logic step, wrap;
  logic [3:0] nxt;
  // synchroniser and edge history run through reset so a steady level never looks like an edge
  always_ff @(posedge clk) begin
    s1 <= bus.tickIn;
    s2 <= s1;
    p <= s2;
  end
  always_comb begin
    step = s2 & ~p & bus.en;
    wrap = bus.up ? bus.count == MAX : bus.count == 4'd0;
    nxt = bus.load ? (bus.loadVal > MAX ? MAX : bus.loadVal) :
          !step ? bus.count :
          wrap ? (bus.up ? 4'd0 : MAX) :
          bus.up ? bus.count + 4'd1 : bus.count - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.count <= 4'd0;
      bus.tc <= 1'b0;
      bus.seg <= hex(4'd0);
    end else begin
      bus.count <= nxt;
      bus.tc <= !bus.load && step && wrap;
      bus.seg <= hex(nxt);
    end
  end
endmodule

// File: tb/tb_tick_counter_seg7.sv
// tb_tick_counter_seg7: directed checks on a MAX_VAL=15 counter and a MAX_VAL=9 counter
module tb_tick_counter_seg7;
  logic clk = 0, rst = 1;
  logic tk = 0, en_a = 0, en_b = 0, up = 1, load = 0;
  logic [3:0] load_val = 0;
  int tests = 0, fails = 0;
  tick_counter_seg7_if ia ();
  tick_counter_seg7_if ib ();
  assign ia.tickIn = tk;
  assign ia.en = en_a;
  assign ia.up = up;
  assign ia.load = load;
  assign ia.loadVal = load_val;
  assign ib.tickIn = tk;
  assign ib.en = en_b;
  assign ib.up = up;
  assign ib.load = load;
  assign ib.loadVal = load_val;
  tick_counter_seg7 #(.MAX_VAL(15), .SEG_ACTIVE_LOW(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  tick_counter_seg7 #(.MAX_VAL(9), .SEG_ACTIVE_LOW(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse();
    tk = 1;
    cyc(2);
    tk = 0;
    cyc(2);
  endtask
  initial begin
    cyc(3);
    chk("rst_count", 32'(ia.count), 0);
    chk("rst_tc", 32'(ia.tc), 0);
    chk("rst_seg", 32'(ia.seg), 32'h40);
    chk("rst_seg_b", 32'(ib.seg), 32'h40);
    tk = 1;
    cyc(3);
    rst = 0;
    en_a = 1;
    cyc(20);
    chk("steady_high_release", 32'(ia.count), 0);
    chk("steady_high_tc", 32'(ia.tc), 0);
    tk = 0;
    cyc(3);
    tk = 1;
    cyc(2);
    chk("latency_k1", 32'(ia.count), 0);
    cyc(1);
    chk("latency_k2", 32'(ia.count), 1);
    chk("seg_1", 32'(ia.seg), 32'h79);
    chk("tc_no_wrap", 32'(ia.tc), 0);
    tk = 0;
    cyc(2);
    for (int i = 0; i < 14; i++) pulse();
    chk("count_15", 32'(ia.count), 15);
    chk("seg_15", 32'(ia.seg), 32'h0E);
    tk = 1;
    cyc(3);
    chk("wrap_up_count", 32'(ia.count), 0);
    chk("wrap_up_tc", 32'(ia.tc), 1);
    chk("wrap_up_seg", 32'(ia.seg), 32'h40);
    cyc(1);
    chk("wrap_up_tc_one", 32'(ia.tc), 0);
    tk = 0;
    cyc(2);
    en_a = 0;
    for (int i = 0; i < 5; i++) pulse();
    chk("en_gate", 32'(ia.count), 0);
    en_a = 1;
    pulse();
    chk("en_resume", 32'(ia.count), 1);
    for (int i = 0; i < 6; i++) pulse();
    chk("count_7", 32'(ia.count), 7);
    tk = 1;
    cyc(2);
    rst = 1;
    cyc(1);
    chk("midrst_count", 32'(ia.count), 0);
    chk("midrst_tc", 32'(ia.tc), 0);
    cyc(2);
    rst = 0;
    cyc(5);
    chk("midrst_no_stale", 32'(ia.count), 0);
    tk = 0;
    cyc(3);
    en_a = 0;
    en_b = 1;
    up = 0;
    tk = 1;
    cyc(3);
    chk("wrap_dn_count", 32'(ib.count), 9);
    chk("wrap_dn_tc", 32'(ib.tc), 1);
    chk("wrap_dn_seg", 32'(ib.seg), 32'h10);
    cyc(1);
    chk("wrap_dn_tc_one", 32'(ib.tc), 0);
    tk = 0;
    cyc(2);
    pulse();
    chk("dn_count_8", 32'(ib.count), 8);
    chk("dn_tc_0", 32'(ib.tc), 0);
    load = 1;
    load_val = 12;
    cyc(1);
    load = 0;
    chk("load_clamp", 32'(ib.count), 9);
    chk("load_clamp_tc", 32'(ib.tc), 0);
    tk = 1;
    cyc(2);
    load = 1;
    load_val = 3;
    cyc(1);
    load = 0;
    chk("load_over_step", 32'(ib.count), 3);
    chk("load_over_step_tc", 32'(ib.tc), 0);
    chk("load_seg", 32'(ib.seg), 32'h30);
    cyc(1);
    chk("load_no_late_step", 32'(ib.count), 3);
    tk = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tick_counter_seg7.md
Name: tick_counter_seg7

Overview:
- Counter stage directly downstream of the clock divider in the 4-bit counter / 7-segment display path.
- Samples the divider's slow square-wave output as data in the single system clock domain and steps a 4-bit counter once per rising edge of it.
- Drives the 7-segment pattern for the current count, plus a one-cycle wrap pulse for cascading.

Parameters:
- MAX_VAL, 15, terminal count; legal range 1..15; the counter wraps between MAX_VAL and 0.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (common-anode); 0 = lit when its bit is 1.

Ports:
- clk  input  1  system clock; the only clock, all flops on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tickIn  input  1  divided-clock level from the clock divider, treated as asynchronous data.
- en  input  1  count enable; qualifies tick edges only.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- loadVal  input  4  value for load.
- count  output  4  current count, registered.
- seg  output  7  segment pattern, registered; bit0 = a ... bit6 = g.
- tc  output  1  one-cycle wrap pulse, registered.

Behaviour:
- Input path: 2-flop synchroniser s1 -> s2, then history flop p; rise = s2 & ~p.
- s1, s2 and p are not affected by rst; they sample every cycle, including during reset.
  - Hold rst for at least 3 cycles.
  - A tickIn level that is steady across reset deassertion then produces no step.
- Step latency: count changes on the 3rd rising clk edge at which tickIn is sampled high, counting the first sampling edge as edge 1. One step per tickIn rising edge regardless of its high or low duration.
- step = rise & en. A tick edge seen while en = 0 is discarded, not queued.
- Priority each cycle: rst > load > step > hold.
- rst: count = 0, tc = 0, seg = decode(0), i.e. 7'h40 when SEG_ACTIVE_LOW = 1, 7'h3F otherwise.
- load: count <= min(loadVal, MAX_VAL).
  - Takes effect on the next edge and is not tick-gated.
  - tc = 0.
  - A coincident step is dropped.
- step, up = 1:
  - count == MAX_VAL -> count <= 0, tc <= 1.
  - Otherwise count <= count + 1.
- step, up = 0:
  - count == 0 -> count <= MAX_VAL, tc <= 1.
  - Otherwise count <= count - 1.
- tc is high for exactly one cycle, the same cycle count first shows the wrapped value; it is 0 in every other cycle.
- count > MAX_VAL is unreachable; all arithmetic is 4-bit, with the wrap handled explicitly, never by natural overflow.
- up and en are sampled in the cycle rise is true. Changing them between ticks has no other effect.
- seg is decoded from the next count value and registered on the same edge as count, so seg always matches count with zero skew.
- Hex decode, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - SEG_ACTIVE_LOW = 1 outputs the bitwise inverse.
- rst asserted mid-count: outputs take their reset values on that edge. A tick edge in flight in the synchroniser is lost if rise coincides with rst.

Test Plan:
- Reset: hold rst 3 cycles with tickIn = 0 -> count = 0, tc = 0, seg = 7'h40. Release with tickIn held high for 20 cycles -> count stays 0.
- Tick latency and up count: en = 1, up = 1; tickIn rises and is first sampled high at edge k -> count becomes 1 at edge k+2 and seg = 7'h79 (~06). 16 tickIn rises from 0 -> count reaches 15 (seg 7'h0E), then 0 with tc = 1 for exactly one cycle.
- Down count and wrap: MAX_VAL = 9, up = 0, count = 0; one tick -> count = 9, tc pulse, seg = 7'h10. Next tick -> count = 8, tc = 0.
- Load: load = 1, loadVal = 12 with MAX_VAL = 9 -> count = 9. load = 1 with loadVal = 3 in the same cycle rise = 1 -> count = 3, no step, tc = 0.
- Enable gating: en = 0 across 5 tick rises -> count unchanged. Then en = 1 -> next rise steps count by exactly 1.
- Mid-run reset: count = 7 with a tick in flight; assert rst -> count = 0, tc = 0 next edge, and no stale step after release.
